level_run_encoder: RTL and testbench

- Downstream consumer of the 1-bit Moore-FSM level output.
- Compresses the per-cycle level stream into (level, run_length) tokens.
- Tokens are buffered in a small FIFO behind a valid/ready interface, for logging or packetisation logic.
- Runs that reach the counter limit are split into multiple tokens.

---
 rtl/level_run_encoder_pkg.sv | 15 +
 rtl/run_token_fifo.sv | 64 ++++++
 rtl/level_run_encoder.sv | 135 +++++++++++++
 tb/tb_level_run_encoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_run_encoder_pkg.sv
// Shared definitions for the level run-length encoder.
//   tracker_state_e : run tracker states (IDLE = no open run, RUN = run open)
//   max_run()       : largest run length a CNT_W-bit field can carry
package level_run_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tracker_state_e;

    function automatic int max_run(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/run_token_fifo.sv
// First-word fall-through token FIFO.
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write one entry at posedge (ignored when full)
//   pop            : discard head entry at posedge (ignored when empty)
//   pop_data       : current head entry, zero while empty
//   count/full/empty : registered occupancy
module run_token_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is not reset; an entry is only visible once count covers it,
    // so clearing the pointers and count is enough to discard stale data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/level_run_encoder.sv
// Compresses a per-cycle 1-bit level stream into (level, run_length) tokens
// and queues them in a small FWFT FIFO behind a valid/ready interface.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_level    : level sample; accepted when in_valid && in_ready
//   in_ready             : a sample can be accepted this cycle
//   flush                : one-cycle request to close the open run
//   out_valid/out_ready  : token handshake at the FIFO head
//   out_level/out_len    : head token, out_len in 1..2^CNT_W-1
module level_run_encoder
    import level_run_encoder_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_level,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_level,
    output logic [CNT_W-1:0] out_len
);

    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] len;
    } token_t;

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(max_run(CNT_W));

    tracker_state_e   state_q, state_d;
    logic             cur_level_q, cur_level_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             flush_pending_q, flush_pending_d;

    logic             push;
    token_t           push_token;
    token_t           head_token;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             do_flush;

    // Never depends on out_ready: a full FIFO blocks input even if it pops.
    assign in_ready = (fifo_count < DEPTH_C) && !flush_pending_q && !flush;
    assign accept   = in_valid && in_ready;
    // A fresh flush acts immediately when there is room; otherwise it waits.
    assign do_flush = flush_pending_q || (flush && (state_q == RUN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cur_level_q     <= 1'b0;
            run_len_q       <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_level_q     <= cur_level_d;
            run_len_q       <= run_len_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        cur_level_d     = cur_level_q;
        run_len_d       = run_len_q;
        flush_pending_d = flush_pending_q;
        push            = 1'b0;
        push_token      = '{level: cur_level_q, len: run_len_q};

        if (do_flush) begin
            // in_ready is low whenever a flush is live, so no sample competes.
            if (!fifo_full) begin
                push            = 1'b1;
                state_d         = IDLE;
                run_len_d       = '0;
                flush_pending_d = 1'b0;
            end else begin
                flush_pending_d = 1'b1;
            end
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    state_d     = RUN;
                    cur_level_d = in_level;
                    run_len_d   = CNT_W'(1);
                end
                RUN: begin
                    if (in_level != cur_level_q) begin
                        push        = 1'b1;
                        cur_level_d = in_level;
                        run_len_d   = CNT_W'(1);
                    end else if (run_len_q == MAX_RUN) begin
                        // Saturated run: emit a full-length token, the current
                        // sample starts the continuation.
                        push      = 1'b1;
                        run_len_d = CNT_W'(1);
                    end else begin
                        run_len_d = run_len_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    run_token_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(token_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_token),
        .pop       (out_ready),
        .pop_data  (head_token),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_level = head_token.level;
    assign out_len   = head_token.len;

endmodule

// File: tb/tb_level_run_encoder.sv
module tb_level_run_encoder;
    import level_run_encoder_pkg::*;

    typedef struct packed {
        logic       level;
        logic [7:0] len;
    } tok_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_level = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_level;
    logic [7:0] out_len;
    logic       in_ready3, out_valid3, out_level3;
    logic [2:0] out_len3;

    int checks = 0;
    int failures = 0;
    bit chk3 = 1'b0;
    tok_t exp_q[$];
    tok_t exp3_q[$];

    always #5 clk = ~clk;

    level_run_encoder #(.CNT_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_level(in_level),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_level(out_level), .out_len(out_len)
    );

    level_run_encoder #(.CNT_W(3), .DEPTH(4)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_level(in_level),
        .in_ready(in_ready3), .flush(flush), .out_valid(out_valid3),
        .out_ready(out_ready), .out_level(out_level3), .out_len(out_len3)
    );

    // Scoreboard: each token leaving the DUT is matched against the queue.
    always @(negedge clk) begin
        tok_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tok_unexpected got=(%0d,%0d) want=none", out_level, out_len);
            end else begin
                e = exp_q.pop_front();
                if ({out_level, out_len} !== {e.level, e.len}) begin
                    failures++;
                    $display("FAIL tok_order got=(%0d,%0d) want=(%0d,%0d)",
                             out_level, out_len, e.level, e.len);
                end
            end
        end
        if (!reset && chk3 && out_valid3 && out_ready) begin
            checks++;
            if (exp3_q.size() == 0) begin
                failures++;
                $display("FAIL tok3_unexpected got=(%0d,%0d) want=none", out_level3, out_len3);
            end else begin
                e = exp3_q.pop_front();
                if ({out_level3, 5'b0, out_len3} !== {e.level, e.len}) begin
                    failures++;
                    $display("FAIL tok3_order got=(%0d,%0d) want=(%0d,%0d)",
                             out_level3, out_len3, e.level, e.len);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; chk3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        exp3_q.delete();
    endtask

    task automatic expect_tok(input logic lvl, input logic [7:0] len);
        exp_q.push_back('{level: lvl, len: len});
    endtask

    // Drive one sample until it is accepted (bounded); returns at posedge+1.
    task automatic send(input logic lvl);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_level = lvl;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout level=%0d not accepted within 100 cycles", lvl);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && (!chk3 || exp3_q.size() == 0)) break;
        end
        checks++;
        if (exp_q.size() != 0 || (chk3 && exp3_q.size() != 0)) begin
            failures++;
            $display("FAIL %s_drain left=%0d left3=%0d want=0", name, exp_q.size(), exp3_q.size());
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty out_valid=%0b want=0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_level, out_len} !== 10'd0) begin
            failures++;
            $display("FAIL reset_out got=(%0b,%0b,%0d) want=(0,0,0)", out_valid, out_level, out_len);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.run_len_q !== 8'd0 || dut.flush_pending_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_tracker state=%0d len=%0d pend=%0b want=0,0,0",
                     dut.state_q, dut.run_len_q, dut.flush_pending_q);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b want=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [4:0] lv;
        do_reset();
        lv = 5'b00111;  // sent LSB first: 1,1,1,0,0
        out_ready = 1'b1;
        expect_tok(1'b1, 8'd3);
        expect_tok(1'b0, 8'd2);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_level = lv[i];
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if ({out_valid, out_level, out_len} !== {1'b1, 1'b1, 8'd3}) begin
                    failures++;
                    $display("FAIL basic_first_tok got=(%0b,%0b,%0d) want=(1,1,3)",
                             out_valid, out_level, out_len);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        pulse_flush();
        @(negedge clk);
        checks++;
        if ({out_valid, out_level, out_len} !== {1'b1, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL basic_flush_tok got=(%0b,%0b,%0d) want=(1,0,2)", out_valid, out_level, out_len);
        end
        @(posedge clk);
        #1;
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_idle_flush out_valid=%0b want=0", out_valid);
            end
        end
        drain("basic");
    endtask

    task automatic test_max_run();
        do_reset();
        chk3 = 1'b1;
        out_ready = 1'b1;
        exp3_q.push_back('{level: 1'b1, len: 8'd7});
        exp3_q.push_back('{level: 1'b1, len: 8'd2});
        expect_tok(1'b1, 8'd9);
        for (int i = 0; i < 9; i++) send(1'b1);
        pulse_flush();
        drain("max_run");
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || dut.u_fifo.count !== 3'd4) begin
            failures++;
            $display("FAIL stall_full in_ready=%0b count=%0d want=0,4", in_ready, dut.u_fifo.count);
        end
        in_valid = 1'b1;
        in_level = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold in_ready=%0b want=0", in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_bypass in_ready=%0b want=0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume in_ready=%0b want=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        pulse_flush();
        drain("stall");
    endtask

    task automatic test_flush_full();
        do_reset();
        out_ready = 1'b0;
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        expect_tok(1'b0, 8'd1);
        send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        pulse_flush();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (dut.u_fifo.count !== 3'd4 || in_ready !== 1'b0 || dut.flush_pending_q !== 1'b1) begin
                failures++;
                $display("FAIL flush_full_wait count=%0d in_ready=%0b pend=%0b want=4,0,1",
                         dut.u_fifo.count, in_ready, dut.flush_pending_q);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.u_fifo.count !== 3'd3 || dut.flush_pending_q !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_full_pop count=%0d pend=%0b in_ready=%0b want=3,1,0",
                     dut.u_fifo.count, dut.flush_pending_q, in_ready);
        end
        @(negedge clk);
        checks++;
        if (dut.u_fifo.count !== 3'd4 || dut.flush_pending_q !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL flush_full_push count=%0d pend=%0b state=%0d want=4,0,IDLE",
                     dut.u_fifo.count, dut.flush_pending_q, dut.state_q);
        end
        drain("flush_full");
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send(1'b1); send(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1);
        @(negedge clk);
        checks++;
        if (dut.u_fifo.count !== 3'd2 || dut.run_len_q !== 8'd5) begin
            failures++;
            $display("FAIL reset_mid_setup count=%0d len=%0d want=2,5", dut.u_fifo.count, dut.run_len_q);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_out_valid got=%0b want=0", out_valid);
        end
        out_ready = 1'b1;
        expect_tok(1'b1, 8'd1);
        @(posedge clk);
        #1;
        send(1'b1);
        pulse_flush();
        drain("reset_mid");
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        expect_tok(1'b0, 8'd1);
        expect_tok(1'b1, 8'd1);
        send(1'b0); send(1'b1); send(1'b0);
        in_valid = 1'b1;
        in_level = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.u_fifo.count !== 3'd2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pre count=%0d in_ready=%0b want=2,1", dut.u_fifo.count, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.u_fifo.count !== 3'd2 || {out_valid, out_level, out_len} !== {1'b1, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL b2b_post count=%0d head=(%0b,%0b,%0d) want=2,(1,1,1)",
                     dut.u_fifo.count, out_valid, out_level, out_len);
        end
        @(posedge clk);
        #1;
        pulse_flush();
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_run();
        test_stall();
        test_flush_full();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
